// File: rtl/round_referee.sv
// Round referee: watches the frog for a goal or a collision, emits one
// win/lose pulse per round, freezes the board for FREEZE_TICKS game ticks,
// then pulses respawn. It waits for the goal/collision condition to clear
// before it arms for the next round.
module round_referee #(
    parameter logic [3:0] GOAL_ROW     = 4'd15,
    parameter int         FREEZE_TICKS = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] frog_row,
    input  logic       collision,
    input  logic       tick,
    output logic       win,
    output logic       lose,
    output logic       freeze,
    output logic       respawn,
    output logic [1:0] debug_state
);

    // PLAY=0, WIN_HOLD=1, LOSE_HOLD=2, REARM=3 (also visible on debug_state)
    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        WIN_HOLD  = 2'd1,
        LOSE_HOLD = 2'd2,
        REARM     = 2'd3
    } state_t;

    localparam logic [7:0] FREEZE_LAST = 8'(FREEZE_TICKS);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       win_d, lose_d, freeze_d, respawn_d;
    logic [7:0] cnt_inc;
    logic       goal;

    assign goal    = (frog_row == GOAL_ROW);
    // Counter never exceeds FREEZE_TICKS-1 before incrementing, so no wrap.
    assign cnt_inc = cnt_q + 8'd1;

    // State, counter and all outputs are registered; outputs carry no input path.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= PLAY;
            cnt_q   <= 8'd0;
            win     <= 1'b0;
            lose    <= 1'b0;
            freeze  <= 1'b0;
            respawn <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win     <= win_d;
            lose    <= lose_d;
            freeze  <= freeze_d;
            respawn <= respawn_d;
        end
    end

    // Next-state, counter and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_d     = 1'b0;
        lose_d    = 1'b0;
        respawn_d = 1'b0;
        case (state_q)
            PLAY: begin
                // Collision outranks the goal when both occur together.
                if (collision) begin
                    lose_d  = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = LOSE_HOLD;
                end else if (goal) begin
                    win_d   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = WIN_HOLD;
                end
            end
            WIN_HOLD, LOSE_HOLD: begin
                // Board inputs are ignored; only ticks advance the hold.
                if (tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == FREEZE_LAST) begin
                        respawn_d = 1'b1;
                        state_d   = REARM;
                    end
                end
            end
            REARM: begin
                // Stale goal/collision from the last round must clear first.
                if (!goal && !collision) begin
                    state_d = PLAY;
                end
            end
            default: begin
                state_d = PLAY;
            end
        endcase
        freeze_d = (state_d == WIN_HOLD) || (state_d == LOSE_HOLD);
    end

    assign debug_state = state_q;

endmodule

// File: tb/tb_round_referee.sv
// Directed bench for round_referee with GOAL_ROW=15, FREEZE_TICKS=8.
module tb_round_referee;

    logic       clock;
    logic       reset;
    logic [3:0] frog_row;
    logic       collision;
    logic       tick;
    logic       win;
    logic       lose;
    logic       freeze;
    logic       respawn;
    logic [1:0] debug_state;

    int tests  = 0;
    int failed = 0;

    localparam logic [1:0] S_PLAY = 2'd0, S_WIN = 2'd1, S_LOSE = 2'd2, S_REARM = 2'd3;

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    round_referee #(.GOAL_ROW(4'd15), .FREEZE_TICKS(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .frog_row    (frog_row),
        .collision   (collision),
        .tick        (tick),
        .win         (win),
        .lose        (lose),
        .freeze      (freeze),
        .respawn     (respawn),
        .debug_state (debug_state)
    );

    // scoreboard: expected outcome sequence vs observed pulses
    // event codes: 1 = win, 2 = lose
    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];
    logic       logging = 1'b0;
    int         both_cnt = 0;

    always @(negedge clock) begin
        if (win && lose) both_cnt++;
        if (logging && win)  obs_q.push_back(2'd1);
        if (logging && lose) obs_q.push_back(2'd2);
    end

    // driver tasks
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // eight back-to-back ticks; respawn must show after the 8th
    task automatic full_hold(input string tag);
        for (int i = 1; i <= 8; i++) begin
            tick = 1'b1;
            step();
            if (i == 7) check({tag, "_freeze7"}, {7'd0, freeze}, 8'd1);
        end
        tick = 1'b0;
        check({tag, "_respawn"}, {7'd0, respawn}, 8'd1);
        check({tag, "_unfreeze"}, {7'd0, freeze}, 8'd0);
        check({tag, "_rearm"}, {6'd0, debug_state}, {6'd0, S_REARM});
    endtask

    initial begin
        reset = 1'b1; frog_row = 4'd0; collision = 1'b0; tick = 1'b0;
        step();
        step();
        check("rst_win", {7'd0, win}, 8'd0);
        check("rst_lose", {7'd0, lose}, 8'd0);
        check("rst_freeze", {7'd0, freeze}, 8'd0);
        check("rst_respawn", {7'd0, respawn}, 8'd0);
        check("rst_state", {6'd0, debug_state}, {6'd0, S_PLAY});

        // goal held 5 cycles: one win, one cycle after the first sample
        reset = 1'b0; frog_row = 4'd15;
        step();
        check("goal_win", {7'd0, win}, 8'd1);
        check("goal_freeze", {7'd0, freeze}, 8'd1);
        check("goal_lose", {7'd0, lose}, 8'd0);
        check("goal_state", {6'd0, debug_state}, {6'd0, S_WIN});
        for (int i = 0; i < 4; i++) begin
            step();
            check("goal_single", {7'd0, win}, 8'd0);
        end

        // 8 ticks spaced 3 cycles apart
        for (int i = 1; i <= 8; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            if (i < 8) begin
                check("spaced_freeze", {7'd0, freeze}, 8'd1);
                check("spaced_norespawn", {7'd0, respawn}, 8'd0);
                step();
                step();
            end
        end
        check("spaced_respawn", {7'd0, respawn}, 8'd1);
        check("spaced_unfreeze", {7'd0, freeze}, 8'd0);
        check("spaced_rearm", {6'd0, debug_state}, {6'd0, S_REARM});

        // stale goal after respawn: no re-trigger
        for (int i = 0; i < 4; i++) begin
            step();
            check("stale_nowin", {7'd0, win}, 8'd0);
            check("stale_rearm", {6'd0, debug_state}, {6'd0, S_REARM});
            check("stale_respawn", {7'd0, respawn}, 8'd0);
        end
        frog_row = 4'd0;
        step();
        check("rearm_to_play", {6'd0, debug_state}, {6'd0, S_PLAY});
        check("rearm_nowin", {7'd0, win}, 8'd0);
        step();
        frog_row = 4'd15;
        step();
        check("second_win", {7'd0, win}, 8'd1);

        // ticks start while the win pulse is high and count
        frog_row = 4'd0;
        full_hold("early_tick");
        step();
        check("back_to_play", {6'd0, debug_state}, {6'd0, S_PLAY});

        // collision and goal together: lose wins priority
        frog_row = 4'd15; collision = 1'b1;
        step();
        check("both_lose", {7'd0, lose}, 8'd1);
        check("both_nowin", {7'd0, win}, 8'd0);
        check("both_state", {6'd0, debug_state}, {6'd0, S_LOSE});
        check("both_freeze", {7'd0, freeze}, 8'd1);
        step();
        check("both_lose_once", {7'd0, lose}, 8'd0);
        check("both_nowin2", {7'd0, win}, 8'd0);

        // reset in the middle of LOSE_HOLD after 3 ticks
        collision = 1'b0; frog_row = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
        check("midhold_freeze", {7'd0, freeze}, 8'd1);
        reset = 1'b1;
        step();
        check("midrst_freeze", {7'd0, freeze}, 8'd0);
        check("midrst_respawn", {7'd0, respawn}, 8'd0);
        check("midrst_state", {6'd0, debug_state}, {6'd0, S_PLAY});
        reset = 1'b0; collision = 1'b1;
        step();
        check("post_rst_lose", {7'd0, lose}, 8'd1);
        check("post_rst_norespawn", {7'd0, respawn}, 8'd0);
        collision = 1'b0;
        full_hold("lose_hold");
        step();
        check("lose_back_play", {6'd0, debug_state}, {6'd0, S_PLAY});

        // chained rounds into the victory counter: win, lose, win
        logging = 1'b1;
        exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd1);
        frog_row = 4'd15; step(); frog_row = 4'd0;
        full_hold("chain_w1");
        step();
        collision = 1'b1; step(); collision = 1'b0;
        full_hold("chain_l");
        step();
        frog_row = 4'd15; step(); frog_row = 4'd0;
        full_hold("chain_w2");
        step();
        step();
        logging = 1'b0;

        check("chain_count", 8'(obs_q.size()), 8'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            check("chain_order", {6'd0, obs_q.pop_front()}, {6'd0, exp_q.pop_front()});
        end
        check("never_both", 8'(both_cnt), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/round_referee.md
ROUND_REFEREE -- requirements
Module: round_referee

Interface
Parameters:
REQ-001 GOAL_ROW, default 4'd15, frog_row value that counts as reaching the goal.
REQ-002 FREEZE_TICKS, default 8, number of tick pulses the board stays frozen after a win or loss; legal range 1..255.
Ports:
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 frog_row  input  4  current frog row; 0 = start row.
REQ-006 collision  input  1  level; frog overlaps a car or hazard this cycle.
REQ-007 tick  input  1  one-cycle game-tick strobe from the game timer.
REQ-008 win  output  1  one-cycle pulse per round won; feeds the victory counter's win input.
REQ-009 lose  output  1  one-cycle pulse per round lost; feeds the victory counter's lose input.
REQ-010 freeze  output  1  level; high while the board is frozen after an outcome.
REQ-011 respawn  output  1  one-cycle pulse that returns the frog to row 0.

Function
REQ-012 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-013 FSM states SHALL be PLAY, WIN_HOLD, LOSE_HOLD and REARM; there is one 8-bit tick counter.
REQ-014 PLAY, collision sampled high at edge k: the block SHALL drive lose=1 during cycle k+1 only, set freeze=1 from cycle k+1, clear the tick counter and enter LOSE_HOLD.
REQ-015 PLAY, collision low and frog_row==GOAL_ROW at edge k: the block SHALL drive win=1 during cycle k+1 only, set freeze=1 from cycle k+1, clear the tick counter and enter WIN_HOLD.
REQ-016 Collision and goal at the same edge: lose SHALL take priority; the block SHALL emit no win pulse.
REQ-017 win and lose SHALL never be high in the same cycle, and each outcome SHALL produce exactly one pulse regardless of how long the inputs stay asserted.
REQ-018 In WIN_HOLD and LOSE_HOLD, the block SHALL ignore collision and frog_row, and each sampled tick SHALL increment the counter by 1.
REQ-019 A tick sampled in the same cycle the win or lose pulse is high SHALL count.
REQ-020 At the edge that samples the FREEZE_TICKS-th tick, the next cycle SHALL have freeze=0 and respawn=1 for that one cycle, and the FSM SHALL enter REARM.
REQ-021 Ticks sampled in PLAY or REARM SHALL have no effect, and the counter SHALL hold.
REQ-022 REARM: the block SHALL generate no outcome and SHALL keep freeze=0; it SHALL stay in REARM until an edge samples frog_row!=GOAL_ROW and collision==0, then enter PLAY on the following cycle.
REQ-023 The FSM SHALL leave PLAY only on an outcome, and SHALL never re-trigger from a stale goal or collision condition left over from the previous round.
REQ-024 The counter SHALL be 8 bits wide, SHALL not wrap within a hold (it is compared for equality with FREEZE_TICKS), and SHALL clear on every hold entry.

Reset
REQ-025 While reset is sampled high, the block SHALL set the state to PLAY, the counter to 0, and win, lose, freeze and respawn to 0 on the next cycle.
REQ-026 Reset SHALL take priority over all inputs in any state, including mid-hold; the block SHALL emit no respawn pulse on reset exit.
REQ-027 The first edge with reset low SHALL be able to detect an outcome, giving win or lose one cycle later.

Verification (defaults: GOAL_ROW=15, FREEZE_TICKS=8)
REQ-028 Reset 1 cycle, then hold frog_row=15 for 5 cycles with collision=0 -> win pulses once, one cycle after the first sample; freeze rises with it; lose stays 0.
REQ-029 Same cycle frog_row=15 and collision=1 -> lose=1 once and win=0 throughout; FSM is in LOSE_HOLD.
REQ-030 After a win, apply 8 ticks spaced 3 cycles apart -> freeze drops and respawn pulses exactly one cycle after the 8th tick is sampled; 7 ticks alone leave freeze=1.
REQ-031 After respawn, keep frog_row=15 for 4 cycles, then set it to 0 -> no second win; PLAY is entered one cycle after frog_row=0; a later goal yields a new single win.
REQ-032 Assert reset during LOSE_HOLD after 3 ticks -> next cycle freeze=0, respawn=0, state PLAY; a collision on the following edge yields lose one cycle later.
REQ-033 Chain into the victory counter: win, lose, win with full holds -> exactly three one-cycle pulses in that order; the counter sees one event per round.
